control_ingreso_teclado: RTL and testbench

Keypad entry controller that sits directly downstream of the 4×4 keypad scan driver. It turns the driver's raw per-scan key reports (`digito`, `cambio_digito`) into exactly one accepted action per physical key press. It assembles up to `N_DIG` BCD digits into an entry buffer, handles clear, backspace and enter keys, and forwards command keys B/C/D as one-cycle strobes to the application logic.

---
 rtl/teclado_pkg.sv | 37 +++
 rtl/det_soltar.sv | 31 +++
 rtl/control_ingreso_teclado.sv | 134 +++++++++++++
 tb/tb_control_ingreso_teclado.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad entry controller: key codes, FSM encoding
// and command codes, plus small decode helpers.
package teclado_pkg;

  localparam logic [4:0] TECLA_A        = 5'd10;
  localparam logic [4:0] TECLA_B        = 5'd11;
  localparam logic [4:0] TECLA_C        = 5'd12;
  localparam logic [4:0] TECLA_D        = 5'd13;
  localparam logic [4:0] TECLA_E        = 5'd14;
  localparam logic [4:0] TECLA_F        = 5'd15;
  localparam logic [4:0] TECLA_NINGUNA  = 5'd16;
  localparam logic [4:0] TECLA_INVALIDA = 5'd17;

  localparam logic [1:0] ST_ESPERA  = 2'd0;
  localparam logic [1:0] ST_PROCESA = 2'd1;
  localparam logic [1:0] ST_SOLTAR  = 2'd2;

  localparam logic [1:0] CMD_B = 2'd0;
  localparam logic [1:0] CMD_C = 2'd1;
  localparam logic [1:0] CMD_D = 2'd2;

  function automatic logic es_digito(input logic [3:0] t);
    return (t <= 4'd9);
  endfunction

  function automatic logic [1:0] cmd_de_tecla(input logic [3:0] t);
    logic [1:0] r;
    case ({1'b0, t})
      TECLA_B: r = CMD_B;
      TECLA_C: r = CMD_C;
      TECLA_D: r = CMD_D;
      default: r = CMD_B;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/det_soltar.sv
// Key-release detector: counts consecutive event-free clocks while armed and
// flags a release once the count reaches RELEASE_TICKS-1 on a quiet clock.
module det_soltar #(
  parameter int RELEASE_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic evento,
  output logic soltado
);

  localparam int CW = $clog2(RELEASE_TICKS);
  localparam logic [CW-1:0] CUENTA_MAX = CW'(RELEASE_TICKS - 1);

  logic [CW-1:0] cuenta;

  assign soltado = arm && !evento && (cuenta == CUENTA_MAX);

  // Release counter; any report restarts the quiet interval.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (!arm || evento) begin
      cuenta <= '0;
    end else if (!soltado) begin
      cuenta <= cuenta + CW'(1);
    end
  end

endmodule

// File: rtl/control_ingreso_teclado.sv
// Keypad entry controller: one accepted action per physical key press, BCD
// entry buffer with clear/backspace/enter, and command strobes for B/C/D.
module control_ingreso_teclado
  import teclado_pkg::*;
#(
  parameter int N_DIG         = 4,
  parameter int RELEASE_TICKS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   digito,
  input  logic                         cambio_digito,
  output logic [4*N_DIG-1:0]           numero,
  output logic [$clog2(N_DIG+1)-1:0]   cant,
  output logic                         listo,
  output logic [1:0]                   comando,
  output logic                         comando_valido,
  output logic                         error,
  output logic                         ocupado
);

  localparam int CW = $clog2(N_DIG + 1);
  localparam int NW = 4 * N_DIG;

  logic [1:0]    estado;
  logic [3:0]    tecla;
  logic          nuevo;
  logic          soltado;
  logic [NW-1:0] tecla_ext;

  assign tecla_ext = NW'(tecla);

  // The counter also runs during PROCESA so re-arm takes exactly
  // RELEASE_TICKS quiet clocks after the last report.
  det_soltar #(
    .RELEASE_TICKS(RELEASE_TICKS)
  ) u_det_soltar (
    .clk    (clk),
    .rst_n  (rst_n),
    .arm    (estado != ST_ESPERA),
    .evento (cambio_digito),
    .soltado(soltado)
  );

  // Press FSM with registered buffer, strobes and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado         <= ST_ESPERA;
      tecla          <= 4'd0;
      nuevo          <= 1'b0;
      numero         <= '0;
      cant           <= '0;
      listo          <= 1'b0;
      comando        <= CMD_B;
      comando_valido <= 1'b0;
      error          <= 1'b0;
      ocupado        <= 1'b0;
    end else begin
      listo          <= 1'b0;
      comando_valido <= 1'b0;
      error          <= 1'b0;
      case (estado)
        ST_ESPERA: begin
          if (cambio_digito && (digito < TECLA_NINGUNA)) begin
            tecla   <= digito[3:0];
            estado  <= ST_PROCESA;
            ocupado <= 1'b1;
          end
        end
        ST_PROCESA: begin
          estado <= ST_SOLTAR;
          if (es_digito(tecla)) begin
            if (nuevo) begin
              numero <= tecla_ext;
              cant   <= CW'(1);
              nuevo  <= 1'b0;
            end else if (cant < CW'(N_DIG)) begin
              numero <= (numero << 4) | tecla_ext;
              cant   <= cant + CW'(1);
            end else begin
              error <= 1'b1;
            end
          end else begin
            case ({1'b0, tecla})
              TECLA_A: begin
                numero <= '0;
                cant   <= '0;
                nuevo  <= 1'b0;
              end
              TECLA_B, TECLA_C, TECLA_D: begin
                comando        <= cmd_de_tecla(tecla);
                comando_valido <= 1'b1;
              end
              TECLA_E: begin
                if (nuevo) begin
                  numero <= '0;
                  cant   <= '0;
                  nuevo  <= 1'b0;
                end else if (cant != '0) begin
                  numero <= numero >> 4;
                  cant   <= cant - CW'(1);
                end else begin
                  error <= 1'b1;
                end
              end
              TECLA_F: begin
                if (cant != '0) begin
                  listo <= 1'b1;
                  nuevo <= 1'b1;
                end else begin
                  error <= 1'b1;
                end
              end
              default: begin
                error <= 1'b1;
              end
            endcase
          end
        end
        ST_SOLTAR: begin
          if (soltado) begin
            estado  <= ST_ESPERA;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= ST_ESPERA;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_ingreso_teclado.sv
// Directed bench for control_ingreso_teclado: a table of key presses with
// hand-computed buffer/pulse expectations, plus multi-cycle corner sequences.
module tb_control_ingreso_teclado;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  digito;
  logic        cambio_digito;
  logic [15:0] numero;
  logic [2:0]  cant;
  logic        listo;
  logic [1:0]  comando;
  logic        comando_valido;
  logic        error;
  logic        ocupado;

  int n_checks = 0;
  int n_fail   = 0;
  int n_listo  = 0;
  int n_error  = 0;
  int n_cmd    = 0;

  control_ingreso_teclado #(.N_DIG(4), .RELEASE_TICKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .digito(digito), .cambio_digito(cambio_digito),
    .numero(numero), .cant(cant), .listo(listo), .comando(comando),
    .comando_valido(comando_valido), .error(error), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tecla;
    logic [15:0] numero;
    logic [2:0]  cant;
    int          n_listo;
    int          n_error;
    int          n_cmd;
    logic [1:0]  comando;
  } vec_t;

  localparam int NV = 23;
  vec_t tabla [0:NV-1];

  function automatic vec_t mk(input logic [4:0] t, input logic [15:0] n, input logic [2:0] c,
                              input int l, input int e, input int m, input logic [1:0] cmd);
    vec_t v;
    v.tecla = t; v.numero = n; v.cant = c;
    v.n_listo = l; v.n_error = e; v.n_cmd = m; v.comando = cmd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, wait past the edge, then tally pulses.
  task automatic ciclo(input logic [4:0] d, input logic c);
    digito = d;
    cambio_digito = c;
    @(posedge clk);
    #1;
    if (listo) n_listo++;
    if (error) n_error++;
    if (comando_valido) n_cmd++;
    chk("pulsos_exclusivos", 32'(int'(listo) + int'(error) + int'(comando_valido) > 1), 32'd0);
  endtask

  task automatic reposo(input int n);
    for (int i = 0; i < n; i++) ciclo(5'd16, 1'b0);
  endtask

  // Key held 8 clocks with a driver report every 4th clock, then released.
  task automatic pulsar(input logic [4:0] t);
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) ciclo(t, 1'b1);
      else            ciclo(5'd16, 1'b0);
    end
    reposo(12);
  endtask

  task automatic limpiar_contadores();
    n_listo = 0; n_error = 0; n_cmd = 0;
  endtask

  initial begin
    tabla[0]  = mk(5'd1,  16'h0001, 3'd1, 0, 0, 0, 2'd0);
    tabla[1]  = mk(5'd2,  16'h0012, 3'd2, 0, 0, 0, 2'd0);
    tabla[2]  = mk(5'd3,  16'h0123, 3'd3, 0, 0, 0, 2'd0);
    tabla[3]  = mk(5'd15, 16'h0123, 3'd3, 1, 0, 0, 2'd0);
    tabla[4]  = mk(5'd10, 16'h0000, 3'd0, 0, 0, 0, 2'd0);
    tabla[5]  = mk(5'd1,  16'h0001, 3'd1, 0, 0, 0, 2'd0);
    tabla[6]  = mk(5'd2,  16'h0012, 3'd2, 0, 0, 0, 2'd0);
    tabla[7]  = mk(5'd3,  16'h0123, 3'd3, 0, 0, 0, 2'd0);
    tabla[8]  = mk(5'd4,  16'h1234, 3'd4, 0, 0, 0, 2'd0);
    tabla[9]  = mk(5'd5,  16'h1234, 3'd4, 0, 1, 0, 2'd0);
    tabla[10] = mk(5'd10, 16'h0000, 3'd0, 0, 0, 0, 2'd0);
    tabla[11] = mk(5'd9,  16'h0009, 3'd1, 0, 0, 0, 2'd0);
    tabla[12] = mk(5'd8,  16'h0098, 3'd2, 0, 0, 0, 2'd0);
    tabla[13] = mk(5'd14, 16'h0009, 3'd1, 0, 0, 0, 2'd0);
    tabla[14] = mk(5'd15, 16'h0009, 3'd1, 1, 0, 0, 2'd0);
    tabla[15] = mk(5'd6,  16'h0006, 3'd1, 0, 0, 0, 2'd0);
    tabla[16] = mk(5'd12, 16'h0006, 3'd1, 0, 0, 1, 2'd1);
    tabla[17] = mk(5'd10, 16'h0000, 3'd0, 0, 0, 0, 2'd1);
    tabla[18] = mk(5'd15, 16'h0000, 3'd0, 0, 1, 0, 2'd1);
    tabla[19] = mk(5'd14, 16'h0000, 3'd0, 0, 1, 0, 2'd1);
    tabla[20] = mk(5'd13, 16'h0000, 3'd0, 0, 0, 1, 2'd2);
    tabla[21] = mk(5'd11, 16'h0000, 3'd0, 0, 0, 1, 2'd0);
    tabla[22] = mk(5'd0,  16'h0000, 3'd1, 0, 0, 0, 2'd0);

    rst_n = 1'b0;
    digito = 5'd16;
    cambio_digito = 1'b0;
    reposo(3);
    chk("reset_numero", 32'(numero), 32'h0);
    chk("reset_cant", 32'(cant), 32'd0);
    chk("reset_listo", 32'(listo), 32'd0);
    chk("reset_comando", 32'(comando), 32'd0);
    chk("reset_cmd_valido", 32'(comando_valido), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    rst_n = 1'b1;
    reposo(2);

    for (int v = 0; v < NV; v++) begin
      limpiar_contadores();
      pulsar(tabla[v].tecla);
      chk($sformatf("v%0d_numero", v), 32'(numero), 32'(tabla[v].numero));
      chk($sformatf("v%0d_cant", v), 32'(cant), 32'(tabla[v].cant));
      chk($sformatf("v%0d_listo", v), 32'(n_listo), 32'(tabla[v].n_listo));
      chk($sformatf("v%0d_error", v), 32'(n_error), 32'(tabla[v].n_error));
      chk($sformatf("v%0d_cmd_valido", v), 32'(n_cmd), 32'(tabla[v].n_cmd));
      chk($sformatf("v%0d_comando", v), 32'(comando), 32'(tabla[v].comando));
      chk($sformatf("v%0d_ocupado", v), 32'(ocupado), 32'd0);
    end

    // Codes 16/17 with a report strobe are ignored.
    ciclo(5'd17, 1'b1);
    ciclo(5'd16, 1'b1);
    chk("invalida_ocupado", 32'(ocupado), 32'd0);
    chk("invalida_cant", 32'(cant), 32'd1);

    // Exact latency: F after digit 0, buffer has cant=1.
    limpiar_contadores();
    ciclo(5'd15, 1'b1);
    chk("lat_ocupado_N", 32'(ocupado), 32'd1);
    chk("lat_listo_N", 32'(listo), 32'd0);
    ciclo(5'd16, 1'b0);
    chk("lat_listo_N1", 32'(listo), 32'd1);
    ciclo(5'd16, 1'b0);
    chk("lat_listo_N2", 32'(listo), 32'd0);
    reposo(12);

    // E right after F clears instead of backspacing, without error.
    limpiar_contadores();
    pulsar(5'd14);
    chk("e_tras_f_cant", 32'(cant), 32'd0);
    chk("e_tras_f_error", 32'(n_error), 32'd0);

    // Long hold of 7: one digit only.
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) ciclo(5'd7, 1'b1);
      else            ciclo(5'd16, 1'b0);
    end
    reposo(12);
    chk("mant_numero", 32'(numero), 32'h0007);
    chk("mant_cant", 32'(cant), 32'd1);

    // Re-arm boundary: 7 quiet clocks swallow the next key, 8 accept it.
    pulsar(5'd10);
    ciclo(5'd5, 1'b1);
    reposo(7);
    ciclo(5'd6, 1'b1);
    reposo(12);
    chk("rearm7_numero", 32'(numero), 32'h0005);
    ciclo(5'd2, 1'b1);
    reposo(8);
    chk("rearm8_ocupado", 32'(ocupado), 32'd0);
    ciclo(5'd3, 1'b1);
    reposo(12);
    chk("rearm8_numero", 32'(numero), 32'h0523);
    chk("rearm8_cant", 32'(cant), 32'd3);

    // Roll-over to another key during SOLTAR is swallowed.
    pulsar(5'd10);
    ciclo(5'd4, 1'b1);
    reposo(3);
    ciclo(5'd8, 1'b1);
    reposo(12);
    chk("rollover_numero", 32'(numero), 32'h0004);

    // Reset in SOLTAR with the key still held, then accepted once.
    pulsar(5'd10);
    ciclo(5'd9, 1'b1);
    reposo(3);
    chk("pre_rst_cant", 32'(cant), 32'd1);
    chk("pre_rst_ocupado", 32'(ocupado), 32'd1);
    rst_n = 1'b0;
    ciclo(5'd9, 1'b1);
    chk("rst_numero", 32'(numero), 32'h0);
    chk("rst_cant", 32'(cant), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_comando", 32'(comando), 32'd0);
    rst_n = 1'b1;
    reposo(3);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) ciclo(5'd9, 1'b1);
      else            ciclo(5'd16, 1'b0);
    end
    reposo(12);
    chk("post_rst_numero", 32'(numero), 32'h0009);
    chk("post_rst_cant", 32'(cant), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
